// File: rtl/demux_edge_counter.sv
// Per-channel rising-edge counters for the eight demux outputs, with saturation
// flags and a one-cycle-latency read port that can optionally clear on read.
module demux_edge_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       ch_in,
  input  logic             clr_all,
  input  logic             rd_req,
  input  logic [2:0]       rd_ch,
  input  logic             rd_clr,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       sat_flags,
  output logic             any_sat
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt      [8];
  logic [WIDTH-1:0] cnt_next [8];
  logic [7:0]       prev;
  logic [7:0]       edge_det;
  logic [7:0]       sat_next;

  assign edge_det = ch_in & ~prev & {8{en}};
  assign any_sat  = |sat_flags;

  // Per channel, highest priority first: clr_all, clear-on-read, increment.
  always_comb begin
    sat_next = sat_flags;
    for (int k = 0; k < 8; k++) begin
      cnt_next[k] = cnt[k];
      if (clr_all) begin
        cnt_next[k] = '0;
        sat_next[k] = 1'b0;
      end else if (rd_req && rd_clr && (rd_ch == 3'(k))) begin
        cnt_next[k] = edge_det[k] ? CNT_ONE : '0;
        sat_next[k] = 1'b0;
      end else if (edge_det[k]) begin
        if (cnt[k] == CNT_MAX) begin
          sat_next[k] = 1'b1;
        end else begin
          cnt_next[k] = cnt[k] + CNT_ONE;
        end
      end
    end
  end

  // The read samples the count before this edge's update, so a read that
  // coincides with clr_all or rd_clr still returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        cnt[k] <= '0;
      end
      prev      <= '0;
      sat_flags <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        cnt[k] <= cnt_next[k];
      end
      prev      <= ch_in;
      sat_flags <= sat_next;
      rd_valid  <= rd_req;
      if (rd_req) begin
        rd_data <= cnt[rd_ch];
      end
    end
  end

endmodule

// File: tb/tb_demux_edge_counter.sv
// Scoreboard bench for demux_edge_counter (WIDTH=4): a count/flag model per
// channel predicts read data, which a separate monitor checks on rd_valid.
module tb_demux_edge_counter;

  localparam int WIDTH   = 4;
  localparam int CNT_MAX = (1 << WIDTH) - 1;

  typedef struct {
    int data;
    int due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [7:0]       ch_in;
  logic             clr_all;
  logic             rd_req;
  logic [2:0]       rd_ch;
  logic             rd_clr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [7:0]       sat_flags;
  logic             any_sat;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  int       m_cnt [8];
  bit [7:0] m_sat;
  bit [7:0] m_prev;
  logic [7:0] cur_ch;

  demux_edge_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_in(ch_in), .clr_all(clr_all),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_clr(rd_clr), .rd_valid(rd_valid),
    .rd_data(rd_data), .sat_flags(sat_flags), .any_sat(any_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    m_sat  = '0;
    m_prev = '0;
  endtask

  // Drives one cycle of inputs, predicts the read response and the new state,
  // then advances to the following falling edge.
  task automatic applyStimulus(input logic e, input logic [7:0] ch, input logic ca,
                               input logic rq, input logic [2:0] rc, input logic rcl);
    bit [7:0] rises;
    exp_t     item;
    en = e; ch_in = ch; clr_all = ca; rd_req = rq; rd_ch = rc; rd_clr = rcl;
    cur_ch = ch;
    rises = ch & ~m_prev & {8{e}};
    if (rq) begin
      item.data = m_cnt[rc];
      item.due  = cyc + 1;
      sb_q.push_back(item);
    end
    for (int k = 0; k < 8; k++) begin
      if (ca) begin
        m_cnt[k] = 0;
        m_sat[k] = 1'b0;
      end else if (rq && rcl && (int'(rc) == k)) begin
        m_cnt[k] = rises[k] ? 1 : 0;
        m_sat[k] = 1'b0;
      end else if (rises[k]) begin
        if (m_cnt[k] == CNT_MAX) m_sat[k] = 1'b1;
        else m_cnt[k] = m_cnt[k] + 1;
      end
    end
    m_prev = ch;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, " sat_flags"}, int'(sat_flags), int'(m_sat));
    compare({tag, " any_sat"}, int'(any_sat), int'(|m_sat));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, cur_ch, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic read_ch(input logic [2:0] c, input logic clr);
    applyStimulus(1'b1, cur_ch, 1'b0, 1'b1, c, clr);
  endtask

  task automatic pulse(input logic [7:0] mask, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(e, mask, 1'b0, 1'b0, 3'd0, 1'b0);
      applyStimulus(e, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    end
  endtask

  // Monitor: every rd_valid must match the oldest expectation that is due now;
  // a due expectation without rd_valid is a dropped response.
  int last_data = 0;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      last_data = 0;
    end else if (rd_valid) begin
      if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
        compare("unexpected rd_valid", 1, 0);
      end else begin
        compare("rd_data", int'(rd_data), sb_q[0].data);
        last_data = sb_q[0].data;
        void'(sb_q.pop_front());
      end
    end else begin
      compare("rd_data hold", int'(rd_data), last_data);
      if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        compare("missing rd_valid", 0, 1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ch_in = '0; clr_all = 1'b0;
    rd_req = 1'b0; rd_ch = '0; rd_clr = 1'b0; cur_ch = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare("reset rd_valid", int'(rd_valid), 0);
    compare("reset rd_data", int'(rd_data), 0);
    checkOutput("reset");
    rst = 1'b0;

    for (int c = 0; c < 8; c++) read_ch(3'(c), 1'b0);
    idle(1);
    checkOutput("after reset reads");

    pulse(8'h20, 1'b1, 3);
    for (int c = 0; c < 8; c++) read_ch(3'(c), 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 1'b0);
    read_ch(3'd2, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    pulse(8'h04, 1'b0, 4);
    read_ch(3'd2, 1'b0);

    pulse(8'h80, 1'b1, 17);
    idle(1);
    checkOutput("ch7 saturated");
    read_ch(3'd7, 1'b1);
    read_ch(3'd7, 1'b0);
    checkOutput("ch7 cleared");

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    pulse(8'h02, 1'b1, 6);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 3'd1, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0);
    pulse(8'h02, 1'b1, 5);
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b1, 3'd1, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0);
    checkOutput("same-cycle events");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), 8'($urandom & $urandom),
                    ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      if (i % 25 == 0) checkOutput("random");
    end
    pulse(8'hFF, 1'b1, 16);
    checkOutput("all saturated");

    // Asynchronous reset while a response is on the port; it must vanish at once.
    en = 1'b1; ch_in = 8'h08; cur_ch = 8'h08; rd_req = 1'b1; rd_ch = 3'd3; rd_clr = 1'b0;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compare("async rst rd_valid", int'(rd_valid), 0);
    compare("async rst rd_data", int'(rd_data), 0);
    compare("async rst sat_flags", int'(sat_flags), 0);
    compare("async rst any_sat", int'(any_sat), 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(2);
    for (int c = 0; c < 8; c++) read_ch(3'(c), 1'b0);
    idle(2);
    checkOutput("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
